// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and widths for the CNN layer accelerator job controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_layer_accel_pkg;

  localparam int DATA_W = 128;  // descriptor params / config word width
  localparam int QUAD_N = 4;    // number of compute quads
  localparam int CNT_W  = 16;   // retired-job counter width
  localparam int QIDX_W = 2;    // index width into the quad mask

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_START,
    ST_RUN,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_COMPLETE,
    ST_DONE
  } state_e;

  // One-hot strobe for a single quad index.
  function automatic logic [QUAD_N-1:0] quad_onehot(input logic [QIDX_W-1:0] idx);
    logic [QUAD_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_mask_walker.sv
// Finds the lowest set mask bit at or above a start index.
// Latency: purely combinational.
// Backpressure: none; result is consumed by the controller FSM.
module cnn_layer_accel_mask_walker
  import cnn_layer_accel_pkg::*;
(
  input  logic [QUAD_N-1:0] mask_i,
  input  logic [QIDX_W:0]   from_i,   // one bit wider so "past the last quad" is expressible
  output logic              found_o,
  output logic [QIDX_W-1:0] idx_o
);

  // Priority search from index 0 upward, ignoring bits below from_i.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < QUAD_N; i++) begin
      if (!found_o && mask_i[i] && ((QIDX_W+1)'(i) >= from_i)) begin
        found_o = 1'b1;
        idx_o   = QIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job controller: takes a host descriptor, configures masked quads, starts the job, serves fetches, retires it.
// Latency: job_start one cycle after handshake when no quads are masked; each handshake output reacts one cycle later.
// Backpressure: desc_ready only in IDLE; config/start/complete strobes hold until the quad accepts.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_pkg::*;
(
  input  logic              clk_if,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [DATA_W-1:0] desc_params,
  input  logic [DATA_W-1:0] desc_cfg_data,
  input  logic [QUAD_N-1:0] desc_quad_mask,
  output logic [QUAD_N-1:0] config_valid,
  input  logic [QUAD_N-1:0] config_accept,
  output logic [DATA_W-1:0] config_data,
  output logic              job_start,
  input  logic              job_accept,
  output logic [DATA_W-1:0] job_parameters,
  input  logic              job_fetch_request,
  output logic              job_fetch_ack,
  output logic              job_fetch_complete,
  output logic              dma_start,
  input  logic              dma_done,
  input  logic              job_complete,
  output logic              job_complete_ack,
  output logic              job_done,
  output logic [CNT_W-1:0]  jobs_done_cnt,
  output logic              busy
);

  state_e              state_q;
  logic                desc_ready_q;
  logic [QUAD_N-1:0]   config_valid_q;
  logic [DATA_W-1:0]   config_data_q;
  logic                job_start_q;
  logic [DATA_W-1:0]   job_parameters_q;
  logic                job_fetch_ack_q;
  logic                job_fetch_complete_q;
  logic                dma_start_q;
  logic                job_complete_ack_q;
  logic                job_done_q;
  logic [CNT_W-1:0]    jobs_done_cnt_q;
  logic [QUAD_N-1:0]   mask_q;
  logic [QIDX_W-1:0]   idx_q;

  logic [QUAD_N-1:0]   walk_mask_d;
  logic [QIDX_W:0]     walk_from_d;
  logic                walk_found;
  logic [QIDX_W-1:0]   walk_idx;

  // In IDLE the walker looks at the incoming mask from bit 0; in CFG it continues past the current quad.
  assign walk_mask_d = (state_q == ST_IDLE) ? desc_quad_mask : mask_q;
  assign walk_from_d = (state_q == ST_IDLE) ? '0 : ({1'b0, idx_q} + (QIDX_W+1)'(1));

  cnn_layer_accel_mask_walker u_walker (
    .mask_i  (walk_mask_d),
    .from_i  (walk_from_d),
    .found_o (walk_found),
    .idx_o   (walk_idx)
  );

  // Job FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state_q              <= ST_IDLE;
      desc_ready_q         <= 1'b1;
      config_valid_q       <= '0;
      config_data_q        <= '0;
      job_start_q          <= 1'b0;
      job_parameters_q     <= '0;
      job_fetch_ack_q      <= 1'b0;
      job_fetch_complete_q <= 1'b0;
      dma_start_q          <= 1'b0;
      job_complete_ack_q   <= 1'b0;
      job_done_q           <= 1'b0;
      jobs_done_cnt_q      <= '0;
      mask_q               <= '0;
      idx_q                <= '0;
    end else begin
      // Single-cycle pulses default low every cycle.
      job_fetch_ack_q      <= 1'b0;
      dma_start_q          <= 1'b0;
      job_fetch_complete_q <= 1'b0;
      job_done_q           <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (desc_valid) begin
            job_parameters_q <= desc_params;
            config_data_q    <= desc_cfg_data;
            mask_q           <= desc_quad_mask;
            desc_ready_q     <= 1'b0;
            if (walk_found) begin
              idx_q          <= walk_idx;
              config_valid_q <= quad_onehot(walk_idx);
              state_q        <= ST_CFG;
            end else begin
              job_start_q    <= 1'b1;
              state_q        <= ST_START;
            end
          end
        end
        ST_CFG: begin
          // Only the accept bit of the quad currently strobed counts.
          if (config_accept[idx_q]) begin
            if (walk_found) begin
              idx_q          <= walk_idx;
              config_valid_q <= quad_onehot(walk_idx);
            end else begin
              config_valid_q <= '0;
              job_start_q    <= 1'b1;
              state_q        <= ST_START;
            end
          end
        end
        ST_START: begin
          if (job_accept) begin
            job_start_q <= 1'b0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A fetch wins over a simultaneous completion; completion is re-sampled on return.
          if (job_fetch_request) begin
            job_fetch_ack_q <= 1'b1;
            dma_start_q     <= 1'b1;
            state_q         <= ST_FETCH_REQ;
          end else if (job_complete) begin
            job_complete_ack_q <= 1'b1;
            state_q            <= ST_COMPLETE;
          end
        end
        ST_FETCH_REQ: begin
          state_q <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          if (dma_done) begin
            job_fetch_complete_q <= 1'b1;
            state_q              <= ST_RUN;
          end
        end
        ST_COMPLETE: begin
          if (!job_complete) begin
            job_complete_ack_q <= 1'b0;
            job_done_q         <= 1'b1;
            jobs_done_cnt_q    <= jobs_done_cnt_q + CNT_W'(1);
            state_q            <= ST_DONE;
          end
        end
        ST_DONE: begin
          desc_ready_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign desc_ready         = desc_ready_q;
  assign config_valid       = config_valid_q;
  assign config_data        = config_data_q;
  assign job_start          = job_start_q;
  assign job_parameters     = job_parameters_q;
  assign job_fetch_ack      = job_fetch_ack_q;
  assign job_fetch_complete = job_fetch_complete_q;
  assign dma_start          = dma_start_q;
  assign job_complete_ack   = job_complete_ack_q;
  assign job_done           = job_done_q;
  assign jobs_done_cnt      = jobs_done_cnt_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Scoreboard bench for the job controller: driver pushes expected output events, monitor pops and compares.
// Latency: n/a.
// Backpressure: driver responds to strobes with randomized delays.
module tb_cnn_layer_accel_job_ctrl;

  localparam int K_CFG   = 0;
  localparam int K_START = 1;
  localparam int K_CDATA = 2;
  localparam int K_FACK  = 3;
  localparam int K_DMA   = 4;
  localparam int K_FCMP  = 5;
  localparam int K_CACK  = 6;
  localparam int K_DONE  = 7;
  localparam int K_PSTAB = 8;

  typedef struct {
    int           kind;
    logic [127:0] val;
  } ev_t;

  logic         clk_if = 1'b0;
  logic         rst;
  logic         desc_valid;
  logic         desc_ready;
  logic [127:0] desc_params;
  logic [127:0] desc_cfg_data;
  logic [3:0]   desc_quad_mask;
  logic [3:0]   config_valid;
  logic [3:0]   config_accept;
  logic [127:0] config_data;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         dma_start;
  logic         dma_done;
  logic         job_complete;
  logic         job_complete_ack;
  logic         job_done;
  logic [15:0]  jobs_done_cnt;
  logic         busy;

  ev_t          exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  model_cnt = 16'd0;
  logic [3:0]   cv_prev = 4'd0;
  logic         js_prev = 1'b0;
  logic         ca_prev = 1'b0;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl dut (
    .clk_if             (clk_if),
    .rst                (rst),
    .desc_valid         (desc_valid),
    .desc_ready         (desc_ready),
    .desc_params        (desc_params),
    .desc_cfg_data      (desc_cfg_data),
    .desc_quad_mask     (desc_quad_mask),
    .config_valid       (config_valid),
    .config_accept      (config_accept),
    .config_data        (config_data),
    .job_start          (job_start),
    .job_accept         (job_accept),
    .job_parameters     (job_parameters),
    .job_fetch_request  (job_fetch_request),
    .job_fetch_ack      (job_fetch_ack),
    .job_fetch_complete (job_fetch_complete),
    .dma_start          (dma_start),
    .dma_done           (dma_done),
    .job_complete       (job_complete),
    .job_complete_ack   (job_complete_ack),
    .job_done           (job_done),
    .jobs_done_cnt      (jobs_done_cnt),
    .busy               (busy)
  );

  function automatic string kname(input int k);
    case (k)
      K_CFG:   return "config_valid";
      K_START: return "job_start_params";
      K_CDATA: return "config_data";
      K_FACK:  return "job_fetch_ack";
      K_DMA:   return "dma_start";
      K_FCMP:  return "job_fetch_complete";
      K_CACK:  return "job_complete_ack";
      K_DONE:  return "job_done_cnt";
      K_PSTAB: return "params_at_done";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int k, input logic [127:0] v);
    exp_q.push_back('{k, v});
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input int k, input logic [127:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_%s: got 0x%0h while no event was expected", kname(k), v);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.val !== v) begin
      errors++;
      $display("FAIL sb_%s: got %s=0x%0h, required %s=0x%0h", kname(k), kname(k), v, kname(e.kind), e.val);
    end
  endtask

  // Monitor: every observable output event is matched against the next expected one.
  always @(negedge clk_if) begin
    if (!rst) begin
      cv_prev = 4'd0;
      js_prev = 1'b0;
      ca_prev = 1'b0;
    end else begin
      if (config_valid != 4'd0 && config_valid != cv_prev) sb_check(K_CFG, 128'(config_valid));
      if (job_start && !js_prev) begin
        sb_check(K_START, job_parameters);
        sb_check(K_CDATA, config_data);
      end
      if (job_fetch_ack)              sb_check(K_FACK, 128'(1));
      if (dma_start)                  sb_check(K_DMA, 128'(1));
      if (job_fetch_complete)         sb_check(K_FCMP, 128'(1));
      if (job_complete_ack && !ca_prev) sb_check(K_CACK, 128'(1));
      if (job_done) begin
        sb_check(K_DONE, 128'(jobs_done_cnt));
        sb_check(K_PSTAB, job_parameters);
      end
      cv_prev = config_valid;
      js_prev = job_start;
      ca_prev = job_complete_ack;
    end
  end

  function automatic bit sig(input int s);
    case (s)
      0:       return desc_ready;
      1:       return config_valid != 4'd0;
      2:       return job_start;
      3:       return dma_start;
      4:       return job_complete_ack;
      5:       return job_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int s, input string nm);
    int n = 0;
    while (!sig(s) && n < 200) begin
      @(negedge clk_if);
      n++;
    end
    if (!sig(s)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: still low after %0d cycles, required high", nm, n);
    end
  endtask

  // Reference model: a descriptor yields one strobe per set mask bit in ascending order,
  // then a start carrying the registered params/cfg word.
  task automatic expect_front(input logic [3:0] m, input logic [127:0] p, input logic [127:0] c);
    for (int q = 0; q < 4; q++) begin
      if (m[q]) push(K_CFG, 128'(1) << q);
    end
    push(K_START, p);
    push(K_CDATA, c);
  endtask

  task automatic run_front(input logic [3:0] m, input logic [127:0] p, input logic [127:0] c,
                           input int acc_dly);
    wait_hi(0, "desc_ready");
    desc_params    = p;
    desc_cfg_data  = c;
    desc_quad_mask = m;
    desc_valid     = 1'b1;
    @(negedge clk_if);
    desc_valid     = 1'b0;
    desc_params    = {$urandom(), $urandom(), $urandom(), $urandom()};
    desc_cfg_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    desc_quad_mask = 4'($urandom());
    chk("desc_ready_after_hs", 128'(desc_ready), 128'(0));
    if (m == 4'd0) chk("start_cycle_after_hs", 128'(job_start), 128'(1));
    for (int q = 0; q < 4; q++) begin
      if (m[q]) begin
        wait_hi(1, "config_valid");
        for (int d = 0; d < acc_dly; d++) begin
          config_accept = ~config_valid;
          @(negedge clk_if);
        end
        config_accept = config_valid | 4'($urandom());
        @(negedge clk_if);
        config_accept = 4'd0;
      end
    end
    wait_hi(2, "job_start");
    repeat ($urandom_range(0, 2)) @(negedge clk_if);
    job_accept = 1'b1;
    @(negedge clk_if);
    job_accept = 1'b0;
    chk("start_low_after_accept", 128'(job_start), 128'(0));
  endtask

  task automatic do_job(input logic [3:0] m, input logic [127:0] p, input logic [127:0] c,
                        input int acc_dly, input int nf, input int dma_dly, input bit collide);
    expect_front(m, p, c);
    for (int f = 0; f < nf; f++) begin
      push(K_FACK, 128'(1));
      push(K_DMA, 128'(1));
      push(K_FCMP, 128'(1));
    end
    push(K_CACK, 128'(1));
    model_cnt = model_cnt + 16'd1;
    push(K_DONE, 128'(model_cnt));
    push(K_PSTAB, p);

    run_front(m, p, c, acc_dly);
    if ($urandom_range(0, 1) == 1) begin
      dma_done = 1'b1;           // stray done while in RUN
      @(negedge clk_if);
      dma_done = 1'b0;
    end
    for (int f = 0; f < nf; f++) begin
      job_fetch_request = 1'b1;
      if (collide && f == nf - 1) job_complete = 1'b1;
      @(negedge clk_if);
      job_fetch_request = 1'b0;
      wait_hi(3, "dma_start");
      repeat (dma_dly) @(negedge clk_if);
      dma_done = 1'b1;
      @(negedge clk_if);
      dma_done = 1'b0;
    end
    job_complete = 1'b1;
    wait_hi(4, "job_complete_ack");
    repeat ($urandom_range(0, 2)) @(negedge clk_if);
    job_complete = 1'b0;
    wait_hi(5, "job_done");
    @(negedge clk_if);
    wait_hi(0, "desc_ready");
    chk("busy_idle_after_job", 128'(busy), 128'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_desc_ready"}, 128'(desc_ready), 128'(1));
    chk({tag, "_ctrl_bits"}, 128'({config_valid, job_start, job_fetch_ack, job_fetch_complete,
                                    dma_start, job_complete_ack, job_done, busy}), 128'(0));
    chk({tag, "_config_data"}, config_data, 128'(0));
    chk({tag, "_job_parameters"}, job_parameters, 128'(0));
    chk({tag, "_jobs_done_cnt"}, 128'(jobs_done_cnt), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] rp;
    logic [127:0] rc;
    rst = 1'b0;
    desc_valid = 1'b0; desc_params = '0; desc_cfg_data = '0; desc_quad_mask = 4'd0;
    config_accept = 4'd0; job_accept = 1'b0; job_fetch_request = 1'b0;
    dma_done = 1'b0; job_complete = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk_if);
    rst = 1'b1;

    // Handshake-side inputs while idle must be ignored.
    job_complete = 1'b1; job_fetch_request = 1'b1; dma_done = 1'b1; job_accept = 1'b1; config_accept = 4'hF;
    @(negedge clk_if);
    job_complete = 1'b0; job_fetch_request = 1'b0; dma_done = 1'b0; job_accept = 1'b0; config_accept = 4'h0;
    @(negedge clk_if);
    chk("idle_noise_busy", 128'(busy), 128'(0));
    chk("idle_noise_ready", 128'(desc_ready), 128'(1));

    rp = {$urandom(), $urandom(), $urandom(), $urandom()};
    rc = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_job(4'b1010, rp, rc, 3, 1, 2, 1'b0);
    do_job(4'b0000, {16{8'hA5}}, rc, 0, 1, 3, 1'b0);
    do_job(4'b1111, rp, ~rc, 1, 3, 10, 1'b0);
    do_job(4'b0110, ~rp, rc, 0, 1, 4, 1'b1);

    for (int j = 0; j < 10; j++) begin
      int nf;
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = {$urandom(), $urandom(), $urandom(), $urandom()};
      nf = $urandom_range(0, 3);
      do_job(4'($urandom()), rp, rc, $urandom_range(0, 3), nf, $urandom_range(1, 5),
             (nf > 0) && ($urandom_range(0, 1) == 1));
    end

    // Reset while waiting for the DMA: job is abandoned, nothing retires.
    rp = {$urandom(), $urandom(), $urandom(), $urandom()};
    rc = {$urandom(), $urandom(), $urandom(), $urandom()};
    expect_front(4'b0101, rp, rc);
    push(K_FACK, 128'(1));
    push(K_DMA, 128'(1));
    run_front(4'b0101, rp, rc, 1);
    job_fetch_request = 1'b1;
    @(negedge clk_if);
    job_fetch_request = 1'b0;
    wait_hi(3, "dma_start");
    @(negedge clk_if);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midjob_reset");
    model_cnt = 16'd0;
    dma_done = 1'b1;
    @(negedge clk_if);
    dma_done = 1'b0;
    rst = 1'b1;
    @(negedge clk_if);
    chk("midjob_reset_no_pending", 128'(exp_q.size()), 128'(0));
    chk("midjob_reset_cnt", 128'(jobs_done_cnt), 128'(0));
    do_job(4'b0001, rp, rc, 0, 1, 1, 1'b0);

    // Counter wrap from 0xFFFF.
    wait_hi(0, "desc_ready");
    force dut.jobs_done_cnt_q = 16'hFFFF;
    @(negedge clk_if);
    release dut.jobs_done_cnt_q;
    @(negedge clk_if);
    model_cnt = 16'hFFFF;
    chk("cnt_preload", 128'(jobs_done_cnt), 128'(16'hFFFF));
    do_job(4'b1000, ~rp, ~rc, 0, 0, 1, 1'b0);
    chk("cnt_wrapped", 128'(jobs_done_cnt), 128'(0));
    do_job(4'b0011, rp, ~rc, 2, 2, 3, 1'b0);

    repeat (5) @(negedge clk_if);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
